// File: rtl/issue_ctrl.sv
// issue_ctrl: decode/execute issue controller.
// Tracks in-flight register writes in a per-register pending-count
// scoreboard, generates the decode stall and sequences the post-redirect
// flush window.
//
// Optional feature: define ISSUE_PERF_EN to add the stall_cycles and
// flush_events performance counter outputs.
//
// FSM states
//   state | meaning
//   RUN   | normal issue; hazards evaluated, stall may assert
//   FLUSH | flush held high after a redirect; nothing issues, stall is 0

module issue_ctrl #(
    parameter int NUM_REGS     = 32,
    parameter int CNT_W        = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rs1_addr,
    input  logic        dec_rs1_used,
    input  logic [4:0]  dec_rs2_addr,
    input  logic        dec_rs2_used,
    input  logic [4:0]  dec_rd_addr,
    input  logic        dec_rd_wr,
    input  logic        dec_serialize,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd_addr,
    input  logic        redirect_valid,
`ifdef ISSUE_PERF_EN
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_events,
`endif
    output logic        stall,
    output logic        flush,
    output logic        sb_empty,
    output logic        sb_error
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t           state;
    logic [FW-1:0]    flush_cnt;
    logic [CNT_W-1:0] cnt     [NUM_REGS];
    logic [CNT_W-1:0] cnt_nxt [NUM_REGS];
    logic             all_zero_nxt;
    logic             err_set;

    logic             rs1_trk;
    logic             rs2_trk;
    logic             rd_trk;
    logic             wb_trk;
    logic             raw_hzd;
    logic             ovf_hzd;
    logic             ser_hzd;
    logic             issue;
    logic             rd_inc;

    // Register 0 is hardwired and addresses past NUM_REGS are not tracked.
    function automatic logic tracked(input logic [4:0] addr);
        return (addr != 5'd0) && (32'(addr) < 32'(NUM_REGS));
    endfunction

    // Hazard detection and issue decision from current registered state.
    always_comb begin
        rs1_trk = tracked(dec_rs1_addr);
        rs2_trk = tracked(dec_rs2_addr);
        rd_trk  = tracked(dec_rd_addr);
        wb_trk  = tracked(wb_rd_addr);
        raw_hzd = (dec_rs1_used && rs1_trk && (cnt[dec_rs1_addr] != '0)) ||
                  (dec_rs2_used && rs2_trk && (cnt[dec_rs2_addr] != '0));
        ovf_hzd = dec_rd_wr && rd_trk && (cnt[dec_rd_addr] == CNT_MAX);
        ser_hzd = dec_serialize && !sb_empty;
        stall   = dec_valid && (state == RUN) && (raw_hzd || ovf_hzd || ser_hzd);
        issue   = dec_valid && !stall && !flush;
        rd_inc  = issue && dec_rd_wr && rd_trk;
        err_set = wb_valid && wb_trk && (cnt[wb_rd_addr] == '0);
    end

    // Next pending counts; a matching issue and writeback cancel out.
    always_comb begin
        all_zero_nxt = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            logic inc;
            logic dec;
            inc        = rd_inc && (dec_rd_addr == 5'(i));
            dec        = wb_valid && wb_trk && (wb_rd_addr == 5'(i));
            cnt_nxt[i] = cnt[i];
            if (inc && !dec) begin
                cnt_nxt[i] = cnt[i] + 1'b1;
            end else if (dec && !inc && (cnt[i] != '0)) begin
                cnt_nxt[i] = cnt[i] - 1'b1;
            end
            if (cnt_nxt[i] != '0) begin
                all_zero_nxt = 1'b0;
            end
        end
    end

    // Scoreboard counters plus registered empty flag and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= '0;
            end
            sb_empty <= 1'b1;
            sb_error <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            sb_empty <= all_zero_nxt;
            if (err_set) begin
                sb_error <= 1'b1;
            end
        end
    end

    // Redirect/flush sequencer; a redirect during FLUSH restarts the window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            flush_cnt <= '0;
            flush     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect_valid) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                        flush     <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (redirect_valid) begin
                        flush_cnt <= FLUSH_LOAD;
                    end else if (flush_cnt == '0) begin
                        state <= RUN;
                        flush <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= RUN;
                    flush <= 1'b0;
                end
            endcase
        end
    end

`ifdef ISSUE_PERF_EN
    // Saturating stall-cycle count and wrapping redirect count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (redirect_valid) begin
                flush_events <= flush_events + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed self-checking bench for issue_ctrl.
module tb_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        dec_valid;
    logic [4:0]  dec_rs1_addr;
    logic        dec_rs1_used;
    logic [4:0]  dec_rs2_addr;
    logic        dec_rs2_used;
    logic [4:0]  dec_rd_addr;
    logic        dec_rd_wr;
    logic        dec_serialize;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic        redirect_valid;
    logic        stall;
    logic        flush;
    logic        sb_empty;
    logic        sb_error;
`ifdef ISSUE_PERF_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_events;
`endif

    int n_cmp;
    int n_bad;

    issue_ctrl #(.NUM_REGS(32), .CNT_W(2), .FLUSH_CYCLES(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .dec_valid      (dec_valid),
        .dec_rs1_addr   (dec_rs1_addr),
        .dec_rs1_used   (dec_rs1_used),
        .dec_rs2_addr   (dec_rs2_addr),
        .dec_rs2_used   (dec_rs2_used),
        .dec_rd_addr    (dec_rd_addr),
        .dec_rd_wr      (dec_rd_wr),
        .dec_serialize  (dec_serialize),
        .wb_valid       (wb_valid),
        .wb_rd_addr     (wb_rd_addr),
        .redirect_valid (redirect_valid),
`ifdef ISSUE_PERF_EN
        .stall_cycles   (stall_cycles),
        .flush_events   (flush_events),
`endif
        .stall          (stall),
        .flush          (flush),
        .sb_empty       (sb_empty),
        .sb_error       (sb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // Apply one cycle of stimulus at the falling edge, then let it settle.
    task automatic step(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic wr, input logic ser,
                        input logic wbv, input logic [4:0] wbrd, input logic redir);
        @(negedge clk);
        dec_valid      = v;
        dec_rs1_addr   = rs1;
        dec_rs1_used   = u1;
        dec_rs2_addr   = rs2;
        dec_rs2_used   = u2;
        dec_rd_addr    = rd;
        dec_rd_wr      = wr;
        dec_serialize  = ser;
        wb_valid       = wbv;
        wb_rd_addr     = wbrd;
        redirect_valid = redir;
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        n_cmp++; if (stall !== 1'b0)    begin n_bad++; $display("FAIL rst_stall: got %b want 0", stall); end
        n_cmp++; if (flush !== 1'b0)    begin n_bad++; $display("FAIL rst_flush: got %b want 0", flush); end
        n_cmp++; if (sb_empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %b want 1", sb_empty); end
        n_cmp++; if (sb_error !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b want 0", sb_error); end
        idle();
        reset = 1'b1;
    endtask

    task automatic test_raw();
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL raw_prod: got %b want 0", stall); end
        step(1, 5, 1, 0, 0, 6, 0, 0, 0, 0, 0);
        n_cmp++; if (stall !== 1'b1)    begin n_bad++; $display("FAIL raw_stall1: got %b want 1", stall); end
        n_cmp++; if (sb_empty !== 1'b0) begin n_bad++; $display("FAIL raw_empty: got %b want 0", sb_empty); end
        step(1, 5, 1, 0, 0, 6, 0, 0, 0, 0, 0);
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL raw_stall2: got %b want 1", stall); end
        step(1, 5, 1, 0, 0, 6, 0, 0, 1, 5, 0);
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL raw_no_bypass: got %b want 1", stall); end
        step(1, 5, 1, 0, 0, 6, 0, 0, 0, 0, 0);
        n_cmp++; if (stall !== 1'b0)    begin n_bad++; $display("FAIL raw_release: got %b want 0", stall); end
        n_cmp++; if (sb_empty !== 1'b1) begin n_bad++; $display("FAIL raw_empty2: got %b want 1", sb_empty); end
        idle();
    endtask

    task automatic test_waw();
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
            n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL waw_fill%0d: got %b want 0", k, stall); end
        end
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL waw_ovf: got %b want 1", stall); end
        step(1, 0, 0, 0, 0, 7, 1, 0, 1, 7, 0);
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL waw_ovf_wb: got %b want 1", stall); end
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL waw_issue4: got %b want 0", stall); end
        step(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL waw_rs2: got %b want 1", stall); end
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        n_cmp++; if (sb_empty !== 1'b0) begin n_bad++; $display("FAIL waw_drain2: got %b want 0", sb_empty); end
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        n_cmp++; if (sb_empty !== 1'b0) begin n_bad++; $display("FAIL waw_drain1: got %b want 0", sb_empty); end
        idle();
        n_cmp++; if (sb_empty !== 1'b1) begin n_bad++; $display("FAIL waw_empty: got %b want 1", sb_empty); end
        n_cmp++; if (sb_error !== 1'b0) begin n_bad++; $display("FAIL waw_error: got %b want 0", sb_error); end
    endtask

    task automatic test_same_cycle();
        step(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 9, 1, 0, 1, 9, 0);
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL same_issue: got %b want 0", stall); end
        step(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (sb_empty !== 1'b0) begin n_bad++; $display("FAIL same_empty: got %b want 0", sb_empty); end
        n_cmp++; if (stall !== 1'b1)    begin n_bad++; $display("FAIL same_stall: got %b want 1", stall); end
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        idle();
        n_cmp++; if (sb_empty !== 1'b1) begin n_bad++; $display("FAIL same_cnt1: got %b want 1", sb_empty); end
        n_cmp++; if (sb_error !== 1'b0) begin n_bad++; $display("FAIL same_error: got %b want 0", sb_error); end
    endtask

    task automatic test_flush();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL fl_pre: got %b want 0", flush); end
        step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
        n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL fl_c1: got %b want 1", flush); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fl_c1_stall: got %b want 0", stall); end
        step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
        n_cmp++; if (flush !== 1'b1)    begin n_bad++; $display("FAIL fl_c2: got %b want 1", flush); end
        n_cmp++; if (sb_empty !== 1'b1) begin n_bad++; $display("FAIL fl_noissue: got %b want 1", sb_empty); end
        step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
        n_cmp++; if (flush !== 1'b0)    begin n_bad++; $display("FAIL fl_end: got %b want 0", flush); end
        n_cmp++; if (sb_empty !== 1'b1) begin n_bad++; $display("FAIL fl_noissue2: got %b want 1", sb_empty); end
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
        n_cmp++; if (sb_empty !== 1'b0) begin n_bad++; $display("FAIL fl_issued: got %b want 0", sb_empty); end
        idle();
        // Back-to-back redirects stretch the window by one cycle.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL fl2_c1: got %b want 1", flush); end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL fl2_c2: got %b want 1", flush); end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL fl2_c3: got %b want 1", flush); end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL fl2_end: got %b want 0", flush); end
    endtask

    task automatic test_serialize();
        step(1, 0, 0, 0, 0, 10, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 11, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL ser_stall: got %b want 1", stall); end
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 10, 0);
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL ser_wb1: got %b want 1", stall); end
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 11, 0);
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL ser_wb2: got %b want 1", stall); end
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        n_cmp++; if (sb_empty !== 1'b1) begin n_bad++; $display("FAIL ser_empty: got %b want 1", sb_empty); end
        n_cmp++; if (stall !== 1'b0)    begin n_bad++; $display("FAIL ser_issue: got %b want 0", stall); end
        idle();
    endtask

    task automatic test_error_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        n_cmp++; if (sb_error !== 1'b0) begin n_bad++; $display("FAIL err_x0: got %b want 0", sb_error); end
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        idle();
        n_cmp++; if (sb_error !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b want 1", sb_error); end
        n_cmp++; if (sb_empty !== 1'b1) begin n_bad++; $display("FAIL err_cnt0: got %b want 1", sb_empty); end
        idle();
        n_cmp++; if (sb_error !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", sb_error); end
        step(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0);
        step(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL err_prestall: got %b want 1", stall); end
        #1 reset = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0)    begin n_bad++; $display("FAIL mrst_stall: got %b want 0", stall); end
        n_cmp++; if (sb_empty !== 1'b1) begin n_bad++; $display("FAIL mrst_empty: got %b want 1", sb_empty); end
        n_cmp++; if (sb_error !== 1'b0) begin n_bad++; $display("FAIL mrst_error: got %b want 0", sb_error); end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        step(1, 0, 0, 0, 0, 12, 1, 0, 0, 0, 0);
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL post_rst_issue: got %b want 0", stall); end
        step(1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL post_rst_hazard: got %b want 1", stall); end
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        dec_valid = 0; dec_rs1_addr = 0; dec_rs1_used = 0; dec_rs2_addr = 0;
        dec_rs2_used = 0; dec_rd_addr = 0; dec_rd_wr = 0; dec_serialize = 0;
        wb_valid = 0; wb_rd_addr = 0; redirect_valid = 0;
        test_reset();
        test_raw();
        test_waw();
        test_same_cycle();
        test_flush();
        test_serialize();
        test_error_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
# issue_ctrl

Issue controller between the decode stage and execute. Tracks in-flight register writes in a per-register pending-count scoreboard. Generates the decode `stall` and the pipeline `flush` sequence on a control-flow redirect. Serialises instructions that must wait for an empty pipeline.

## Interface
Parameters:
- NUM_REGS, 32, architectural registers tracked; x0 is never tracked.
- CNT_W, 2, width of each pending counter; at most 2^CNT_W-1 outstanding writes per register.
- FLUSH_CYCLES, 2, number of consecutive cycles `flush` is held after a redirect (>=1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- dec_valid  in  1  decode holds a valid instruction.
- dec_rs1_addr  in  5  source 1 register.
- dec_rs1_used  in  1  instruction reads rs1.
- dec_rs2_addr  in  5  source 2 register.
- dec_rs2_used  in  1  instruction reads rs2.
- dec_rd_addr  in  5  destination register.
- dec_rd_wr  in  1  instruction writes rd.
- dec_serialize  in  1  instruction issues only with an empty scoreboard (e.g. fence/CSR).
- wb_valid  in  1  writeback retires a register write this cycle.
- wb_rd_addr  in  5  register being written back.
- redirect_valid  in  1  execute resolved a taken branch/jump; younger instructions are dead.
- stall  out  1  hold decode and fetch (combinational).
- flush  out  1  kill decode/fetch contents (registered).
- sb_empty  out  1  no write is pending on any register (registered).
- sb_error  out  1  sticky: writeback to a register with zero pending count.

## Operation
- Issue condition: `dec_valid & !stall & !flush`. On issue with `dec_rd_wr` and rd != 0, cnt[rd] increments.
- Writeback: `wb_valid` with wb_rd_addr != 0 decrements cnt[wb_rd_addr].
  - If cnt is already 0, the counter stays 0 and `sb_error` sets; only reset clears it.
  - Writeback to x0 is ignored.
- Same cycle, same register, issue and writeback: net count unchanged.
- Hazard (RAW): `dec_rs1_used` & rs1 != 0 & cnt[rs1] != 0, or the same for rs2.
- WAW overflow: `dec_rd_wr` & rd != 0 & cnt[rd] == 2^CNT_W-1.
- Serialise: `dec_serialize` & !sb_empty.
- stall = dec_valid & state==RUN & (RAW | overflow | serialise). stall = 0 in FLUSH.
- FSM states:
  - RUN: on redirect_valid -> FLUSH, load flush counter with FLUSH_CYCLES-1.
  - FLUSH: `flush`=1. Counter decrements each cycle; at 0 with no redirect -> RUN. redirect_valid in FLUSH reloads the counter and stays in FLUSH.
- Flushed instructions were never issued; the scoreboard is not modified by flush. Older in-flight writes still retire through wb.
- sb_empty = all counters zero, computed from registered state.
- Reset (reset=0, asynchronous): all counters 0, state RUN, flush 0, sb_empty 1, sb_error 0. stall evaluates to 0 because counters are zero and state is RUN.

## Timing
- `stall` is combinational from the current counter state and dec_* inputs, within the same cycle.
- A writeback in cycle N releases a dependent stall in cycle N+1; there is no same-cycle bypass.
- An issue in cycle N makes cnt[rd] visible to hazard checks in cycle N+1.
- redirect_valid sampled at edge N -> `flush` high for cycles N+1 .. N+FLUSH_CYCLES.
- redirect_valid has priority over hazard evaluation; no issue occurs while `flush`=1.
- Reset asserted mid-operation clears all state immediately. The first issue is possible in the first cycle after deassertion.

## Configuration
- ISSUE_PERF_EN defined:
  - Adds output `stall_cycles` (32 bits), incremented every cycle `stall`=1, saturating at 2^32-1.
  - Adds output `flush_events` (16 bits), incremented on each redirect accepted, wrapping.
  - Both reset to 0.
- Undefined: neither port nor its counters exist; behaviour is otherwise identical.

## Test plan
- Issue rd=5 in cycle 0, then in cycle 1 present a consumer with rs1=5 -> stall=1. wb rd=5 in cycle 3 -> stall=0 in cycle 4 and the consumer issues.
- Issue three writes to rd=7 with CNT_W=2 -> cnt=3. A fourth writer to rd=7 stalls until one wb rd=7, then issues.
- Same-cycle issue rd=9 and wb rd=9 with cnt[9]=1 -> cnt stays 1 and sb_empty stays 0.
- redirect_valid pulse at edge 10 with FLUSH_CYCLES=2 -> flush=1 in cycles 11–12, no issue. A second redirect at edge 11 extends flush through cycle 13.
- dec_serialize with two pending writes -> stall until both retire; sb_empty=1 and issue occur in the same cycle.
- wb rd=3 with cnt[3]=0 -> sb_error=1 and sticky. Assert reset mid-stall -> stall=0, sb_empty=1, sb_error=0.
